// File: rtl/alarme_pkg.sv
// Shared state codes and sizing helpers for the alarme_ctrl alarm sequencer.
package alarme_pkg;

  localparam int unsigned StateW = 3;

  localparam logic [StateW-1:0] StDisarmed = 3'd0;
  localparam logic [StateW-1:0] StExit     = 3'd1;
  localparam logic [StateW-1:0] StArmed    = 3'd2;
  localparam logic [StateW-1:0] StEntry    = 3'd3;
  localparam logic [StateW-1:0] StAlarm    = 3'd4;

  localparam int unsigned EventW   = 4;
  localparam int unsigned EventMax = 15;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/alarme_tick.sv
// Prescaler: one-cycle tick every CLK_TICKS cycles, restartable on state change.
module alarme_tick #(
  parameter int unsigned CLK_TICKS = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned PrescW = (CLK_TICKS > 1) ? $clog2(CLK_TICKS) : 1;

  logic [PrescW-1:0] presc_q, presc_d;

  assign tick_o = (presc_q == PrescW'(CLK_TICKS - 1));

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (restart_i || tick_o) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/alarme_ctrl.sv
// Alarm sequencer: exit delay, armed watch, entry delay, timed siren, event counter.
// Define ALARME_ENTRY_DELAY_EN to include the ENTRY delay state.
module alarme_ctrl
  import alarme_pkg::*;
#(
  parameter int unsigned CLK_TICKS   = 1000,
  parameter int unsigned EXIT_TICKS  = 8,
  parameter int unsigned ENTRY_TICKS = 8,
  parameter int unsigned SIREN_TICKS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm_i,
  input  logic              disarm_i,
  input  logic              trig_i,
  output logic              siren_o,
  output logic              armed_o,
  output logic [StateW-1:0] state_o,
  output logic [EventW-1:0] event_cnt_o
);

  localparam int unsigned MaxTicks = max3(EXIT_TICKS, ENTRY_TICKS, SIREN_TICKS);
  localparam int unsigned TimerW   = $clog2(MaxTicks) + 1;

  logic [StateW-1:0] state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [EventW-1:0] cnt_q, cnt_d;
  logic              tick, expired, restart;

  alarme_tick #(
    .CLK_TICKS(CLK_TICKS)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart_i(restart),
    .tick_o   (tick)
  );

  // Last cycle of a timed state: final tick while one tick remains.
  assign expired = tick && (timer_q == TimerW'(1));

  always_comb begin
    state_d = state_q;
    if (disarm_i) begin
      state_d = StDisarmed;
    end else begin
      case (state_q)
        StDisarmed: if (arm_i) state_d = StExit;
        StExit:     if (expired) state_d = StArmed;
`ifdef ALARME_ENTRY_DELAY_EN
        StArmed:    if (trig_i) state_d = StEntry;
        StEntry:    if (expired) state_d = StAlarm;
`else
        StArmed:    if (trig_i) state_d = StAlarm;
`endif
        StAlarm:    if (expired) state_d = StArmed;
        default:    state_d = StDisarmed;
      endcase
    end
  end

  assign restart = (state_d != state_q);

  always_comb begin
    timer_d = timer_q;
    if (restart) begin
      case (state_d)
        StExit:  timer_d = TimerW'(EXIT_TICKS);
`ifdef ALARME_ENTRY_DELAY_EN
        StEntry: timer_d = TimerW'(ENTRY_TICKS);
`endif
        StAlarm: timer_d = TimerW'(SIREN_TICKS);
        default: timer_d = '0;
      endcase
    end else if (tick && (timer_q != '0)) begin
      timer_d = timer_q - 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_d == StAlarm) && (state_q != StAlarm) && (cnt_q != EventW'(EventMax))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StDisarmed;
      timer_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o     = state_q;
  assign event_cnt_o = cnt_q;
  assign siren_o     = (state_q == StAlarm);
`ifdef ALARME_ENTRY_DELAY_EN
  assign armed_o     = (state_q == StArmed) || (state_q == StEntry) || (state_q == StAlarm);
`else
  assign armed_o     = (state_q == StArmed) || (state_q == StAlarm);
`endif

endmodule

// File: tb/tb_alarme_ctrl.sv
// Directed bench for alarme_ctrl; follows ALARME_ENTRY_DELAY_EN to pick ENTRY expectations.
module tb_alarme_ctrl;
  import alarme_pkg::*;

  localparam int unsigned CT = 2;
  localparam int unsigned ET = 3;
  localparam int unsigned NT = 2;
  localparam int unsigned ST = 4;
`ifdef ALARME_ENTRY_DELAY_EN
  localparam int EntryCyc = NT * CT;
`else
  localparam int EntryCyc = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, arm, disarm, trig;
  logic              siren, armed;
  logic [StateW-1:0] state;
  logic [EventW-1:0] event_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt;

  alarme_ctrl #(
    .CLK_TICKS  (CT),
    .EXIT_TICKS (ET),
    .ENTRY_TICKS(NT),
    .SIREN_TICKS(ST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm_i      (arm),
    .disarm_i   (disarm),
    .trig_i     (trig),
    .siren_o    (siren),
    .armed_o    (armed),
    .state_o    (state),
    .event_cnt_o(event_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles, checking state and its Moore outputs at each falling edge.
  task automatic run(input int n, input logic [StateW-1:0] st, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, 32'(state), 32'(st));
      check({tag, "_siren"}, 32'(siren), 32'(st == StAlarm));
      check({tag, "_armed"}, 32'(armed),
            32'((st == StArmed) || (st == StEntry) || (st == StAlarm)));
    end
  endtask

  task automatic arm_to_armed();
    arm = 1'b1;
    run(1, StExit, "arm_exit");
    arm = 1'b0;
    run(ET * CT - 1, StExit, "exit_hold");
    run(1, StArmed, "exit_done");
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; disarm = 1'b0; trig = 1'b0;
    exp_cnt = 0;
    #2;
    check("rst_state", 32'(state), 32'(0));
    check("rst_siren", 32'(siren), 32'(0));
    check("rst_armed", 32'(armed), 32'(0));
    check("rst_cnt", 32'(event_cnt), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Arm with trig high through the whole exit delay.
    trig = 1'b1;
    arm_to_armed();
    check("exit_cnt", 32'(event_cnt), 32'(0));
    trig = 1'b0;

    // Trig pulse in ARMED.
    run(2, StArmed, "armed_idle");
    trig = 1'b1;
`ifdef ALARME_ENTRY_DELAY_EN
    run(1, StEntry, "entry_in");
    trig = 1'b0;
    run(EntryCyc - 1, StEntry, "entry_hold");
    run(1, StAlarm, "alarm_in");
`else
    run(1, StAlarm, "alarm_in");
    trig = 1'b0;
`endif
    exp_cnt = 1;
    check("alarm_cnt1", 32'(event_cnt), 32'(exp_cnt));
    run(ST * CT - 1, StAlarm, "alarm_hold");
    run(1, StArmed, "alarm_done");
    check("alarm_done_cnt", 32'(event_cnt), 32'(exp_cnt));

    // Disarm mid-ENTRY (or mid-ALARM without the entry delay).
    trig = 1'b1;
`ifdef ALARME_ENTRY_DELAY_EN
    run(1, StEntry, "entry2_in");
    trig = 1'b0;
    run(1, StEntry, "entry2_hold");
`else
    run(1, StAlarm, "alarm2_in");
    trig = 1'b0;
    exp_cnt = 2;
    run(1, StAlarm, "alarm2_hold");
`endif
    disarm = 1'b1;
    run(1, StDisarmed, "disarm");
    disarm = 1'b0;
    check("disarm_cnt", 32'(event_cnt), 32'(exp_cnt));
    trig = 1'b1;
    run(2, StDisarmed, "disarmed_trig");
    trig = 1'b0;

    // Arm and disarm together: disarm wins.
    arm = 1'b1; disarm = 1'b1;
    run(1, StDisarmed, "arm_disarm");
    arm = 1'b0; disarm = 1'b0;
    run(1, StDisarmed, "arm_disarm_after");

    // Asynchronous reset in the middle of ALARM.
    arm_to_armed();
    trig = 1'b1;
`ifdef ALARME_ENTRY_DELAY_EN
    run(1, StEntry, "entry3_in");
    trig = 1'b0;
    run(EntryCyc - 1, StEntry, "entry3_hold");
    run(1, StAlarm, "alarm3_in");
`else
    run(1, StAlarm, "alarm3_in");
    trig = 1'b0;
`endif
    exp_cnt++;
    check("alarm3_cnt", 32'(event_cnt), 32'(exp_cnt));
    run(2, StAlarm, "alarm3_hold");
    #1 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'(0));
    check("arst_siren", 32'(siren), 32'(0));
    check("arst_armed", 32'(armed), 32'(0));
    check("arst_cnt", 32'(event_cnt), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;

    // Trig held: repeated alarms, counter saturates.
    arm_to_armed();
    trig = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      run(EntryCyc, StEntry, "sat_entry");
      run(1, StAlarm, "sat_alarm_in");
      exp_cnt = (e > int'(EventMax)) ? int'(EventMax) : e;
      check("sat_cnt", 32'(event_cnt), 32'(exp_cnt));
      run(ST * CT - 1, StAlarm, "sat_alarm_hold");
      run(1, StArmed, "sat_rearm");
    end
    check("sat_final", 32'(event_cnt), 32'(15));
    trig = 1'b0;
    disarm = 1'b1;
    run(1, StDisarmed, "final_disarm");
    disarm = 1'b0;
    check("final_cnt", 32'(event_cnt), 32'(15));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
